rst_sequencer: RTL and testbench

- Parametrised power-up and reset sequencer. It generalises the fixed single-output post-lock delay counter into N staged reset domains.
- It waits for a filtered PLL lock, then holds reset for a power-up delay. It then releases channel resets one by one, with a gap between each (DDC first, then FFT, then check/UART).
- On PLL lock loss it re-asserts every reset. It also accepts a soft-reset request (e.g. from ARM GPIO) that re-runs the staged release without the long power-up wait.
- It sits at chip top between the PLL and every datapath block.

---
 rtl/rst_seq_pkg.sv | 16 +
 rtl/lock_sync_filt.sv | 56 +++++
 rtl/rst_sequencer.sv | 162 ++++++++++++++++
 tb/tb_rst_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged power-up / reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PWRUP = 3'd1,
    ST_REL   = 3'd2,
    ST_RUN   = 3'd3,
    ST_SOFT  = 3'd4
  } state_e;

  localparam int                LOSS_W   = 8;
  localparam logic [LOSS_W-1:0] LOSS_SAT = 8'd255;
  localparam int unsigned       CNT_CLR  = 0;

endpackage

// File: rtl/lock_sync_filt.sv
// Synchronises the asynchronous PLL LOCKED input and filters it so that only
// LOCK_FILT consecutive high samples declare lock; any low sample drops it.
module lock_sync_filt
  import rst_seq_pkg::*;
#(
  parameter int LOCK_FILT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic LOCKED,
  output logic lock_ok,
  output logic lock_fall
);

  localparam int              FILT_W   = $clog2(LOCK_FILT + 1);
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILT);
  localparam logic [FILT_W-1:0] FILT_SET = FILT_W'(LOCK_FILT - 1);

  logic              meta_q, meta_d;
  logic              lk_s_q, lk_s_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic              lock_ok_q, lock_ok_d;
  logic              lock_fall_q, lock_fall_d;

  always_comb begin
    meta_d      = LOCKED;
    lk_s_d      = meta_q;
    filt_d      = '0;
    lock_ok_d   = 1'b0;
    lock_fall_d = lock_ok_q & ~lk_s_q;
    if (lk_s_q) begin
      filt_d    = (filt_q == FILT_MAX) ? filt_q : filt_q + FILT_W'(1);
      lock_ok_d = lock_ok_q | (filt_q == FILT_SET);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta_q      <= 1'b0;
      lk_s_q      <= 1'b0;
      filt_q      <= '0;
      lock_ok_q   <= 1'b0;
      lock_fall_q <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      lk_s_q      <= lk_s_d;
      filt_q      <= filt_d;
      lock_ok_q   <= lock_ok_d;
      lock_fall_q <= lock_fall_d;
    end
  end

  assign lock_ok   = lock_ok_q;
  assign lock_fall = lock_fall_q;

endmodule

// File: rtl/rst_sequencer.sv
// Power-up and reset sequencer: waits for filtered PLL lock, holds a power-up
// delay, then releases N_CH reset domains in order with a gap between each.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 32,
  parameter int PWRUP_DLY = 100_000_000,
  parameter int STAGE_DLY = 1024,
  parameter int LOCK_FILT = 16,
  parameter int SOFT_HOLD = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOCKED,
  input  logic              SOFT_REQ,
  output logic [N_CH-1:0]   RST_OUT,
  output logic              READY,
  output logic [LOSS_W-1:0] LOSS_CNT,
  output logic [2:0]        STATE
);

  localparam int             K_W        = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int             LAST_K     = (N_CH > 1) ? N_CH - 2 : 0;
  localparam logic [K_W-1:0] K_LAST     = K_W'(LAST_K);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(CNT_CLR);
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_DLY - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_HOLD - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [N_CH-1:0]     rst_out_q, rst_out_d;
  logic                ready_q, ready_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;
  logic                soft_q, soft_d;
  logic                soft_prev_q, soft_prev_d;
  logic                lock_ok, lock_fall;
  logic                soft_rise, start_rel, enter_soft;

  lock_sync_filt #(.LOCK_FILT(LOCK_FILT)) u_lock (
    .CLK      (CLK),
    .RST      (RST),
    .LOCKED   (LOCKED),
    .lock_ok  (lock_ok),
    .lock_fall(lock_fall)
  );

  assign soft_rise = soft_q & ~soft_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    rst_out_d   = rst_out_q;
    ready_d     = ready_q;
    loss_d      = loss_q;
    soft_d      = SOFT_REQ;
    soft_prev_d = soft_q;
    start_rel   = 1'b0;
    enter_soft  = 1'b0;

    // Lock loss outranks every other event, including a soft request.
    if (lock_fall && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      cnt_d     = CNT_ZERO;
      k_d       = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
      loss_d    = (loss_q == LOSS_SAT) ? loss_q : loss_q + LOSS_W'(1);
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          cnt_d     = CNT_ZERO;
          k_d       = '0;
          if (lock_ok) state_d = ST_PWRUP;
        end
        ST_PWRUP: begin
          if (cnt_q == PWRUP_LAST) start_rel = 1'b1;
          else                     cnt_d     = cnt_q + CNT_W'(1);
        end
        ST_REL: begin
          if (soft_rise) begin
            enter_soft = 1'b1;
          end else if (cnt_q == STAGE_LAST) begin
            cnt_d     = CNT_ZERO;
            rst_out_d = rst_out_q << 1;
            k_d       = k_q + K_W'(1);
            if (k_q == K_LAST) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (soft_rise) begin
            enter_soft = 1'b1;
          end else begin
            rst_out_d = '0;
            ready_d   = 1'b1;
          end
        end
        ST_SOFT: begin
          if (cnt_q == SOFT_LAST) start_rel = 1'b1;
          else                    cnt_d     = cnt_q + CNT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase

      // Shifting the thermometer releases the next channel without ever
      // re-asserting an already released one.
      if (start_rel) begin
        state_d   = (N_CH == 1) ? ST_RUN : ST_REL;
        cnt_d     = CNT_ZERO;
        k_d       = '0;
        rst_out_d = rst_out_q << 1;
        ready_d   = (N_CH == 1);
      end

      if (enter_soft) begin
        state_d   = ST_SOFT;
        cnt_d     = CNT_ZERO;
        k_d       = '0;
        rst_out_d = '1;
        ready_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      k_q         <= '0;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      loss_q      <= '0;
      soft_q      <= 1'b0;
      soft_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      loss_q      <= loss_d;
      soft_q      <= soft_d;
      soft_prev_q <= soft_prev_d;
    end
  end

  assign RST_OUT  = rst_out_q;
  assign READY    = ready_q;
  assign LOSS_CNT = loss_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected output snapshots are queued per
// clock edge when stimulus is driven and compared when that edge arrives.
module tb_rst_sequencer;

  localparam int N_CH      = 3;
  localparam int PWRUP_DLY = 20;
  localparam int STAGE_DLY = 4;
  localparam int LOCK_FILT = 3;
  localparam int SOFT_HOLD = 5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PWRUP = 3'd1;
  localparam logic [2:0] S_REL   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_SOFT  = 3'd4;

  typedef struct packed {
    int         cyc;
    logic [2:0] rst;
    logic       ready;
    logic [2:0] state;
    logic [7:0] loss;
  } exp_t;

  logic            CLK;
  logic            RST;
  logic            LOCKED;
  logic            SOFT_REQ;
  logic [N_CH-1:0] RST_OUT;
  logic            READY;
  logic [7:0]      LOSS_CNT;
  logic [2:0]      STATE;

  int    cyc = 0;
  int    compareCnt = 0;
  int    mismatchCnt = 0;
  exp_t  sb[$];
  string tagQ[$];
  logic  softWindow = 1'b0;
  logic  sawPwrup = 1'b0;

  rst_sequencer #(
    .N_CH     (N_CH),
    .CNT_W    (32),
    .PWRUP_DLY(PWRUP_DLY),
    .STAGE_DLY(STAGE_DLY),
    .LOCK_FILT(LOCK_FILT),
    .SOFT_HOLD(SOFT_HOLD)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .LOCKED  (LOCKED),
    .SOFT_REQ(SOFT_REQ),
    .RST_OUT (RST_OUT),
    .READY   (READY),
    .LOSS_CNT(LOSS_CNT),
    .STATE   (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCnt++;
    if (observed !== expected) begin
      mismatchCnt++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (edge %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  task automatic pushExp(input string tag, input int atCyc, input logic [2:0] rst,
                         input logic ready, input logic [2:0] state, input logic [7:0] loss);
    exp_t e;
    e.cyc   = atCyc;
    e.rst   = rst;
    e.ready = ready;
    e.state = state;
    e.loss  = loss;
    sb.push_back(e);
    tagQ.push_back(tag);
  endtask

  // Must be called at a falling edge; drives inputs at the falling edge after edge atCyc.
  task automatic applyStimulus(input int atCyc, input logic lk, input logic sr);
    while (cyc < atCyc) @(negedge CLK);
    LOCKED   = lk;
    SOFT_REQ = sr;
  endtask

  // Outputs are sampled on the falling edge, half a period after the active edge.
  always @(negedge CLK) begin
    exp_t  e;
    string t;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      t = tagQ.pop_front();
      if (e.cyc != cyc) checkOutput({t, "_late"}, 32'(cyc), 32'(e.cyc));
      checkOutput({t, "_rst_out"}, 32'(RST_OUT), 32'(e.rst));
      checkOutput({t, "_ready"}, 32'(READY), 32'(e.ready));
      checkOutput({t, "_state"}, 32'(STATE), 32'(e.state));
      checkOutput({t, "_loss"}, 32'(LOSS_CNT), 32'(e.loss));
    end
    if (softWindow && STATE == S_PWRUP) sawPwrup = 1'b1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout at edge %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, t, e0, s, d0, e1, e2, d, e3;

    RST      = 1'b1;
    LOCKED   = 1'b0;
    SOFT_REQ = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    checkOutput("reset_rst_out", 32'(RST_OUT), 32'h7);
    checkOutput("reset_ready", 32'(READY), 32'h0);
    checkOutput("reset_loss", 32'(LOSS_CNT), 32'h0);
    checkOutput("reset_state", 32'(STATE), 32'(S_IDLE));
    @(negedge CLK);
    RST = 1'b0;
    $display("[TB] reset released at edge %0d", cyc);

    // Lock glitches: 2 high, 1 low, four times; filter never reaches 3.
    base = cyc;
    for (int i = 1; i <= 16; i++) pushExp("glitch", base + i, 3'b111, 1'b0, S_IDLE, 8'd0);
    for (int r = 0; r < 4; r++) begin
      applyStimulus(base + 3 * r, 1'b1, 1'b0);
      applyStimulus(base + 3 * r + 2, 1'b0, 1'b0);
    end

    // Power-up with an ignored soft request during PWRUP.
    t  = base + 17;
    e0 = t + 1;
    pushExp("pwr_idle",  e0 + 4,  3'b111, 1'b0, S_IDLE,  8'd0);
    pushExp("pwr_enter", e0 + 5,  3'b111, 1'b0, S_PWRUP, 8'd0);
    pushExp("pwr_soft",  e0 + 12, 3'b111, 1'b0, S_PWRUP, 8'd0);
    pushExp("pwr_hold",  e0 + 24, 3'b111, 1'b0, S_PWRUP, 8'd0);
    pushExp("rel0",      e0 + 25, 3'b110, 1'b0, S_REL,   8'd0);
    pushExp("rel0_hold", e0 + 28, 3'b110, 1'b0, S_REL,   8'd0);
    pushExp("rel1",      e0 + 29, 3'b100, 1'b0, S_REL,   8'd0);
    pushExp("rel1_hold", e0 + 32, 3'b100, 1'b0, S_REL,   8'd0);
    pushExp("run",       e0 + 33, 3'b000, 1'b1, S_RUN,   8'd0);
    applyStimulus(t, 1'b1, 1'b0);
    applyStimulus(e0 + 9, 1'b1, 1'b1);
    applyStimulus(e0 + 11, 1'b1, 1'b0);
    applyStimulus(e0 + 36, 1'b1, 1'b0);

    // Soft reset from RUN.
    t = cyc;
    s = t + 1;
    pushExp("soft_s",    s,      3'b000, 1'b1, S_RUN,  8'd0);
    pushExp("soft_in",   s + 1,  3'b111, 1'b0, S_SOFT, 8'd0);
    pushExp("soft_hold", s + 5,  3'b111, 1'b0, S_SOFT, 8'd0);
    pushExp("soft_rel0", s + 6,  3'b110, 1'b0, S_REL,  8'd0);
    pushExp("soft_rel1", s + 10, 3'b100, 1'b0, S_REL,  8'd0);
    pushExp("soft_pre",  s + 13, 3'b100, 1'b0, S_REL,  8'd0);
    pushExp("soft_run",  s + 14, 3'b000, 1'b1, S_RUN,  8'd0);
    softWindow = 1'b1;
    applyStimulus(t, 1'b1, 1'b1);
    applyStimulus(s + 1, 1'b1, 1'b0);
    applyStimulus(s + 16, 1'b1, 1'b0);
    softWindow = 1'b0;
    checkOutput("soft_no_pwrup", 32'(sawPwrup), 32'h0);

    // Lock loss in RUN.
    t  = cyc;
    d0 = t + 1;
    pushExp("loss_run_pre",  d0 + 2, 3'b000, 1'b1, S_RUN,  8'd0);
    pushExp("loss_run",      d0 + 3, 3'b111, 1'b0, S_IDLE, 8'd1);
    pushExp("loss_run_hold", d0 + 5, 3'b111, 1'b0, S_IDLE, 8'd1);
    applyStimulus(t, 1'b0, 1'b0);
    applyStimulus(d0 + 6, 1'b0, 1'b0);

    // Relock, then lose lock while k = 1 in REL.
    t  = cyc;
    e1 = t + 1;
    pushExp("rl_pwr",      e1 + 24, 3'b111, 1'b0, S_PWRUP, 8'd1);
    pushExp("rl_rel0",     e1 + 25, 3'b110, 1'b0, S_REL,   8'd1);
    pushExp("rl_rel1",     e1 + 29, 3'b100, 1'b0, S_REL,   8'd1);
    pushExp("rl_pre",      e1 + 31, 3'b100, 1'b0, S_REL,   8'd1);
    pushExp("loss_rel",    e1 + 32, 3'b111, 1'b0, S_IDLE,  8'd2);
    pushExp("loss_rel_hd", e1 + 34, 3'b111, 1'b0, S_IDLE,  8'd2);
    applyStimulus(t, 1'b1, 1'b0);
    applyStimulus(e1 + 28, 1'b0, 1'b0);
    applyStimulus(e1 + 36, 1'b0, 1'b0);

    // Relock to RUN, then soft request rising on the same edge as lock loss.
    t  = cyc;
    e2 = t + 1;
    d  = e2 + 36;
    pushExp("col_run",  e2 + 33, 3'b000, 1'b1, S_RUN,  8'd2);
    pushExp("col_pre",  d + 2,   3'b000, 1'b1, S_RUN,  8'd2);
    pushExp("col_loss", d + 3,   3'b111, 1'b0, S_IDLE, 8'd3);
    pushExp("col_idle", d + 4,   3'b111, 1'b0, S_IDLE, 8'd3);
    pushExp("col_hold", d + 8,   3'b111, 1'b0, S_IDLE, 8'd3);
    applyStimulus(t, 1'b1, 1'b0);
    applyStimulus(d - 1, 1'b0, 1'b0);
    applyStimulus(d + 1, 1'b0, 1'b1);
    applyStimulus(d + 4, 1'b0, 1'b0);
    applyStimulus(d + 10, 1'b0, 1'b0);

    // Relock, then asynchronous reset between clock edges while k = 1.
    t  = cyc;
    e3 = t + 1;
    pushExp("ar_rel0", e3 + 25, 3'b110, 1'b0, S_REL, 8'd3);
    pushExp("ar_rel1", e3 + 29, 3'b100, 1'b0, S_REL, 8'd3);
    applyStimulus(t, 1'b1, 1'b0);
    applyStimulus(e3 + 30, 1'b1, 1'b0);
    checkOutput("ar_pre_rst_out", 32'(RST_OUT), 32'h4);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("ar_rst_out", 32'(RST_OUT), 32'h7);
    checkOutput("ar_ready", 32'(READY), 32'h0);
    checkOutput("ar_state", 32'(STATE), 32'(S_IDLE));
    checkOutput("ar_loss", 32'(LOSS_CNT), 32'h0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    checkOutput("sb_drain", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
    $finish;
  end

endmodule
